// File: rtl/hdmi_video_timing.sv
// Raster timing generator: qualifies PLL lock, then scans (h,v) over the full
// raster and presents registered hsync/vsync/de/sof and pixel coordinates.
module hdmi_video_timing #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter int SYNC_POL = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pll_locked,
   output logic        running,
   output logic        de,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] x,
   output logic [11:0] y,
   output logic        sof
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
   localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic        SYNC_ACT   = (SYNC_POL != 0);
   localparam logic        SYNC_IDLE  = ~SYNC_ACT;

   logic        lock_meta;
   logic [11:0] h_cnt;
   logic [11:0] v_cnt;

   logic        de_d;
   logic        hs_d;
   logic        vs_d;
   logic        sof_d;
   logic [11:0] x_d;
   logic [11:0] y_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta <= 1'b0;
         running   <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         running   <= lock_meta;
      end
   end

   // Losing lock drops the raster immediately; the next lock restarts at (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= 12'd0;
         v_cnt <= 12'd0;
      end else if (!running) begin
         h_cnt <= 12'd0;
         v_cnt <= 12'd0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= 12'd0;
         v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
         h_cnt <= h_cnt + 12'd1;
      end
   end

   // Counters can still be non-zero on the first cycle after running falls,
   // so every decode term is gated by running.
   always_comb begin
      de_d  = 1'b0;
      hs_d  = 1'b0;
      vs_d  = 1'b0;
      sof_d = 1'b0;
      x_d   = 12'd0;
      y_d   = 12'd0;
      if (running) begin
         de_d  = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
         hs_d  = (h_cnt >= HS_START) && (h_cnt < HS_END);
         vs_d  = (v_cnt >= VS_START) && (v_cnt < VS_END);
         sof_d = (h_cnt == 12'd0) && (v_cnt == 12'd0);
         x_d   = h_cnt;
         y_d   = v_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de    <= 1'b0;
         hsync <= SYNC_IDLE;
         vsync <= SYNC_IDLE;
         sof   <= 1'b0;
         x     <= 12'd0;
         y     <= 12'd0;
      end else begin
         de    <= de_d;
         hsync <= hs_d ? SYNC_ACT : SYNC_IDLE;
         vsync <= vs_d ? SYNC_ACT : SYNC_IDLE;
         sof   <= sof_d;
         x     <= x_d;
         y     <= y_d;
      end
   end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing on a reduced 14x7 raster, checked against a
// cycle-count reference model (position = cycles since lock qualified).
module tb_hdmi_video_timing;

   localparam int HA  = 8;
   localparam int HFP = 2;
   localparam int HSW = 2;
   localparam int HBP = 2;
   localparam int VA  = 4;
   localparam int VFP = 1;
   localparam int VSW = 1;
   localparam int VBP = 1;
   localparam int HT  = HA + HFP + HSW + HBP;
   localparam int VT  = VA + VFP + VSW + VBP;
   localparam int FT  = HT * VT;
   localparam logic POL  = 1'b1;
   localparam logic IDLE = 1'b0;
   localparam logic [28:0] RST_VEC = {1'b0, 1'b0, IDLE, IDLE, 1'b0, 12'd0, 12'd0};

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        pll_locked = 1'b0;
   logic        running, de, hsync, vsync, sof;
   logic [11:0] x, y;
   logic [28:0] got;

   int n_checks = 0;
   int n_pass   = 0;

   hdmi_video_timing #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .running(running),
      .de(de), .hsync(hsync), .vsync(vsync), .x(x), .y(y), .sof(sof)
   );

   always #5 clk = ~clk;

   assign got = {running, de, hsync, vsync, sof, x, y};

   // Reference: lock seen two edges late; position is cycles since then mod frame.
   logic m_s1 = 1'b0;
   logic m_run = 1'b0;
   int   m_cnt = -1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = 1'b0; m_run = 1'b0; m_cnt = -1;
      end else begin
         if (m_run) m_cnt = m_cnt + 1;
         else       m_cnt = -1;
         m_run = m_s1;
         m_s1  = pll_locked;
      end
   end

   function automatic logic [28:0] model_out();
      int p, h, v;
      logic d, hs, vs, sf;
      if (m_cnt < 0) return {m_run, 1'b0, IDLE, IDLE, 1'b0, 12'd0, 12'd0};
      p  = m_cnt % FT;
      h  = p % HT;
      v  = p / HT;
      d  = (h < HA) && (v < VA);
      hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
      vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
      sf = (p == 0);
      return {m_run, d, hs ? POL : IDLE, vs ? POL : IDLE, sf, 12'(h), 12'(v)};
   endfunction

   task automatic test_reset();
      logic [28:0] exp;
      pll_locked = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (got !== RST_VEC) $display("FAIL reset_hold got=%h exp=%h", got, RST_VEC);
      else n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         exp = model_out();
         n_checks++;
         if (got !== RST_VEC || exp !== RST_VEC)
            $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, got, RST_VEC);
         else n_pass++;
      end
   endtask

   task automatic test_lock_start();
      int de_cnt = 0;
      logic [28:0] exp;
      pll_locked = 1'b1;
      @(negedge clk);
      n_checks++;
      if (running !== 1'b0) $display("FAIL lock_run_early got=%b exp=0", running);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (running !== 1'b1) $display("FAIL lock_run_rise got=%b exp=1", running);
      else n_pass++;
      for (int i = 0; i < HT; i++) begin
         @(negedge clk);
         exp = model_out();
         if (i == 0) begin
            n_checks++;
            if ({sof, de, x, y} !== {1'b1, 1'b1, 12'd0, 12'd0})
               $display("FAIL lock_first_px got sof=%b de=%b x=%0d y=%0d exp 1 1 0 0", sof, de, x, y);
            else n_pass++;
         end
         if (de === 1'b1) de_cnt++;
         n_checks++;
         if (got !== exp) $display("FAIL lock_line cyc=%0d got=%h exp=%h", i, got, exp);
         else n_pass++;
      end
      n_checks++;
      if (de_cnt != HA) $display("FAIL lock_de_count got=%0d exp=%0d", de_cnt, HA);
      else n_pass++;
   endtask

   task automatic test_hsync();
      int hs_cnt = 0;
      int first_x = -1;
      int y0;
      int guard = 0;
      while (x !== 12'(HT - 1) && guard < 2 * FT) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (guard >= 2 * FT) $display("FAIL hsync_wait got=timeout exp=x_at_end");
      else n_pass++;
      @(negedge clk);
      y0 = int'(y);
      n_checks++;
      if (x !== 12'd0) $display("FAIL hsync_wrap_x got=%0d exp=0", x);
      else n_pass++;
      for (int i = 0; i < HT; i++) begin
         if (hsync === POL) begin
            hs_cnt++;
            if (first_x < 0) first_x = int'(x);
         end
         n_checks++;
         if (x !== 12'(i) || int'(y) != y0) $display("FAIL hsync_line_pos got=%0d,%0d exp=%0d,%0d", x, y, i, y0);
         else n_pass++;
         @(negedge clk);
      end
      n_checks++;
      if (x !== 12'd0 || int'(y) != (y0 + 1) % VT)
         $display("FAIL hsync_next_line got=%0d,%0d exp=0,%0d", x, y, (y0 + 1) % VT);
      else n_pass++;
      n_checks++;
      if (hs_cnt != HSW || first_x != HA + HFP)
         $display("FAIL hsync_width got=%0d@%0d exp=%0d@%0d", hs_cnt, first_x, HSW, HA + HFP);
      else n_pass++;
   endtask

   task automatic test_frame();
      int guard = 0;
      int last_sof = 0;
      int vs_cnt = 0;
      logic [28:0] exp;
      while (sof !== 1'b1 && guard < 2 * FT) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (guard >= 2 * FT) $display("FAIL frame_wait got=timeout exp=sof");
      else n_pass++;
      for (int i = 1; i <= 3 * FT; i++) begin
         @(negedge clk);
         exp = model_out();
         n_checks++;
         if (got !== exp) $display("FAIL frame_cmp cyc=%0d got=%h exp=%h", i, got, exp);
         else n_pass++;
         if (vsync === POL) begin
            vs_cnt++;
            n_checks++;
            if (int'(y) < VA + VFP || int'(y) >= VA + VFP + VSW)
               $display("FAIL vsync_line got=%0d exp=%0d..%0d", y, VA + VFP, VA + VFP + VSW - 1);
            else n_pass++;
         end
         if (sof === 1'b1) begin
            n_checks++;
            if (i - last_sof != FT) $display("FAIL sof_spacing got=%0d exp=%0d", i - last_sof, FT);
            else n_pass++;
            last_sof = i;
         end
      end
      n_checks++;
      if (vs_cnt != 3 * VSW * HT) $display("FAIL vsync_cycles got=%0d exp=%0d", vs_cnt, 3 * VSW * HT);
      else n_pass++;
   endtask

   task automatic test_lock_loss();
      int guard = 0;
      logic [28:0] exp;
      while (!(y === 12'(VT / 2) && x === 12'(HT / 2)) && guard < 2 * FT) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (guard >= 2 * FT) $display("FAIL loss_wait got=timeout exp=mid_frame");
      else n_pass++;
      pll_locked = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         exp = model_out();
         n_checks++;
         if (got !== exp) $display("FAIL loss_cmp cyc=%0d got=%h exp=%h", i, got, exp);
         else n_pass++;
      end
      n_checks++;
      if (got !== RST_VEC) $display("FAIL loss_idle got=%h exp=%h", got, RST_VEC);
      else n_pass++;
      repeat (4) @(negedge clk);
      pll_locked = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({running, sof, de, x, y} !== {1'b1, 1'b1, 1'b1, 12'd0, 12'd0})
         $display("FAIL relock_start got=%b%b%b x=%0d y=%0d exp=111 x=0 y=0", running, sof, de, x, y);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [28:0] exp;
      for (int it = 0; it < 40; it++) begin
         int len = $urandom_range(1, 2 * FT);
         pll_locked = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            n_checks++;
            if (got !== RST_VEC) $display("FAIL async_reset it=%0d got=%h exp=%h", it, got, RST_VEC);
            else n_pass++;
            @(negedge clk);
            rst_n = 1'b1;
         end
         for (int i = 0; i < len; i++) begin
            @(negedge clk);
            exp = model_out();
            n_checks++;
            if (got !== exp) $display("FAIL random it=%0d cyc=%0d got=%h exp=%h", it, i, got, exp);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock_start();
      test_hsync();
      test_frame();
      test_lock_loss();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
